// File: rtl/glitch_filter_pkg.sv
// Shared types and helpers for the time-multiplexed glitch filter.
package glitch_filter_pkg;

  // Default run-counter width; filter lengths span 0..2^CNT_W-1 scans.
  localparam int CNT_W_DEF = 8;

  // Per-channel state as stored in the register file: filtered level above
  // the consecutive-mismatch run counter.
  typedef struct packed {
    logic                 level;
    logic [CNT_W_DEF-1:0] cnt;
  } chan_state_t;

  localparam int CHAN_STATE_W = $bits(chan_state_t);

  // Index width for NUM_CH entries, never narrower than one bit.
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/glitch_filter_scan_ctrl_if.sv
// Channel inputs, filtered outputs, config and event handshakes.
interface glitch_filter_scan_ctrl_if
  import glitch_filter_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DROP_W = 16
) ();

  localparam int AW = clog2w(NUM_CH);

  logic [NUM_CH-1:0] inData;
  logic              cfgValid;
  logic              cfgReady;
  logic [CNT_W-1:0]  cfgLen;
  logic [NUM_CH-1:0] outData;
  logic              evtValid;
  logic              evtReady;
  logic [AW-1:0]     evtCh;
  logic              evtLevel;
  logic [DROP_W-1:0] dropCnt;

  modport master (
    output inData, cfgValid, cfgLen, evtReady,
    input  cfgReady, outData, evtValid, evtCh, evtLevel, dropCnt
  );

  modport slave (
    input  inData, cfgValid, cfgLen, evtReady,
    output cfgReady, outData, evtValid, evtCh, evtLevel, dropCnt
  );

endinterface

// File: rtl/glitch_scan_state_rf.sv
// Per-channel state store: one combinational read and one write port sharing
// the scan address, plus a masked synchronous clear of every entry.
module glitch_scan_state_rf #(
  parameter int DEPTH = 8,
  parameter int W     = 9,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          clrAll,
  input  logic [W-1:0]  clrMask,
  input  logic [AW-1:0] addr,
  output logic [W-1:0]  rdData,
  input  logic          wrEn,
  input  logic [W-1:0]  wrData
);

  logic [W-1:0] mem [DEPTH];

  assign rdData = mem[addr];

  // Write the visited entry; a clear masks bits of every entry and wins over
  // the write, so a level update landing on the clear edge still survives.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (clrAll) begin
        mem[i] <= ((wrEn && addr == AW'(i)) ? wrData : mem[i]) & ~clrMask;
      end else if (wrEn && addr == AW'(i)) begin
        mem[i] <= wrData;
      end
    end
  end

endmodule

// File: rtl/glitch_filter_scan_ctrl.sv
// Scans NUM_CH inputs one per clock through a shared glitch filter and
// reports filtered level changes on a single-entry event register.
module glitch_filter_scan_ctrl
  import glitch_filter_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_LEN = 1,
  parameter int DROP_W      = 16
) (
  input logic                     clk,
  input logic                     rstN,
  glitch_filter_scan_ctrl_if.slave bus
);

  localparam int AW = clog2w(NUM_CH);
  localparam int SW = CNT_W + 1;
  localparam logic [AW-1:0] LAST = AW'(NUM_CH - 1);

  logic [NUM_CH-1:0] sampleReg;
  logic [AW-1:0]     ptr;
  logic [CNT_W-1:0]  lenActive;
  logic [CNT_W-1:0]  pendLen;
  logic              pendValid;
  logic [NUM_CH-1:0] outReg;
  logic              evtValidReg;
  logic [AW-1:0]     evtChReg;
  logic              evtLevelReg;
  logic [DROP_W-1:0] dropReg;

  logic [SW-1:0]     rdState;
  logic [SW-1:0]     wrState;
  logic [SW-1:0]     clrMask;
  logic              clrAll;
  logic              s;
  logic              curLevel;
  logic [CNT_W-1:0]  curCnt;
  logic [CNT_W:0]    runNext;
  logic              change;
  logic              qualify;
  logic              wrap;
  logic              apply;
  logic              xfer;

  // Visit decision for the channel under the scan pointer.
  always_comb begin
    curLevel = rdState[SW-1];
    curCnt   = rdState[CNT_W-1:0];
    s        = sampleReg[ptr];
    change   = s ^ curLevel;
    runNext  = {1'b0, curCnt} + (CNT_W + 1)'(1);
    qualify  = change && ((lenActive == '0) || (runNext >= {1'b0, lenActive}));
    if (!change) begin
      wrState = {curLevel, {CNT_W{1'b0}}};
    end else if (qualify) begin
      wrState = {s, {CNT_W{1'b0}}};
    end else begin
      wrState = {curLevel, runNext[CNT_W-1:0]};
    end
    wrap    = (ptr == LAST);
    apply   = wrap && pendValid;
    xfer    = bus.cfgValid && !pendValid;
    clrAll  = !rstN || apply;
    clrMask = !rstN ? {SW{1'b1}} : {1'b0, {CNT_W{1'b1}}};
  end

  glitch_scan_state_rf #(
    .DEPTH(NUM_CH),
    .W    (SW),
    .AW   (AW)
  ) u_rf (
    .clk    (clk),
    .clrAll (clrAll),
    .clrMask(clrMask),
    .addr   (ptr),
    .rdData (rdState),
    .wrEn   (rstN),
    .wrData (wrState)
  );

  // Capture the already-synchronised inputs every clock.
  always_ff @(posedge clk) begin
    sampleReg <= bus.inData;
  end

  // Scan pointer and config: a pending length is only applied on the wrap
  // edge, so each scan runs with one length throughout.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      ptr       <= '0;
      lenActive <= CNT_W'(DEFAULT_LEN);
      pendLen   <= '0;
      pendValid <= 1'b0;
    end else begin
      ptr <= wrap ? '0 : ptr + 1'b1;
      if (apply) begin
        lenActive <= pendLen;
      end
      if (xfer) begin
        pendValid <= 1'b1;
        pendLen   <= bus.cfgLen;
      end else if (apply) begin
        pendValid <= 1'b0;
      end
    end
  end

  // Filtered output level of the visited channel.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      outReg <= '0;
    end else if (qualify) begin
      outReg[ptr] <= s;
    end
  end

  // Single-entry event register; a change that finds it full and not being
  // drained is counted as dropped instead of overwriting the held event.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      evtValidReg <= 1'b0;
      evtChReg    <= '0;
      evtLevelReg <= 1'b0;
      dropReg     <= '0;
    end else begin
      if (qualify && (!evtValidReg || bus.evtReady)) begin
        evtValidReg <= 1'b1;
        evtChReg    <= ptr;
        evtLevelReg <= s;
      end else if (evtValidReg && bus.evtReady) begin
        evtValidReg <= 1'b0;
      end
      if (qualify && evtValidReg && !bus.evtReady && (dropReg != {DROP_W{1'b1}})) begin
        dropReg <= dropReg + 1'b1;
      end
    end
  end

  assign bus.cfgReady = !pendValid;
  assign bus.outData  = outReg;
  assign bus.evtValid = evtValidReg;
  assign bus.evtCh    = evtChReg;
  assign bus.evtLevel = evtLevelReg;
  assign bus.dropCnt  = dropReg;

endmodule

// File: tb/tb_glitch_filter_scan_ctrl.sv
// Bench: two instances (4 and 5 channels) checked every cycle against a
// visit-history model, plus directed checks with hand-computed values.
module tb_glitch_filter_scan_ctrl;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  glitch_filter_scan_ctrl_if #(.NUM_CH(4), .CNT_W(8), .DROP_W(6))  bus4 ();
  glitch_filter_scan_ctrl_if #(.NUM_CH(5), .CNT_W(8), .DROP_W(16)) bus5 ();

  glitch_filter_scan_ctrl #(.NUM_CH(4), .CNT_W(8), .DEFAULT_LEN(1), .DROP_W(6)) dut4 (
    .clk(clk), .rstN(rstN), .bus(bus4.slave));
  glitch_filter_scan_ctrl #(.NUM_CH(5), .CNT_W(8), .DEFAULT_LEN(1), .DROP_W(16)) dut5 (
    .clk(clk), .rstN(rstN), .bus(bus5.slave));

  int total = 0;
  int bad   = 0;
  bit cmpEn = 0;
  bit done5 = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: per channel, the history of samples seen on its visits. A change
  // propagates when the last len visits all disagree with the filtered level.
  int mPtr[2];
  int mLen[2];
  bit mPend[2];
  int mPendLen[2];
  bit mLevel[2][5];
  bit mPrev[2][5];
  bit mHist[2][5][$];
  bit mEvV[2];
  int mEvCh[2];
  bit mEvL[2];
  int mDrop[2];
  int mDropMax[2] = '{63, 65535};

  task automatic model_step(input int k, input int n, input logic [4:0] inNow,
                            input logic rstNow, input logic cfgV,
                            input logic [7:0] cfgL, input logic rdy);
    int c;
    int sz;
    bit sv;
    bit lv;
    bit qual;
    bit pendOld;
    if (!rstNow) begin
      for (int i = 0; i < 5; i++) begin
        mLevel[k][i] = 0;
        mHist[k][i].delete();
      end
      mPtr[k] = 0; mLen[k] = 1; mPend[k] = 0; mPendLen[k] = 0;
      mEvV[k] = 0; mEvCh[k] = 0; mEvL[k] = 0; mDrop[k] = 0;
    end else begin
      c  = mPtr[k];
      sv = mPrev[k][c];
      lv = mLevel[k][c];
      mHist[k][c].push_back(sv);
      if (mHist[k][c].size() > 300) void'(mHist[k][c].pop_front());
      sz = mHist[k][c].size();
      qual = 0;
      if (sv != lv) begin
        if (mLen[k] == 0) qual = 1;
        else if (sz >= mLen[k]) begin
          qual = 1;
          for (int i = 0; i < mLen[k]; i++)
            if (mHist[k][c][sz-1-i] == lv) qual = 0;
        end
      end
      if (qual) begin
        mLevel[k][c] = sv;
        if (!mEvV[k] || rdy) begin
          mEvV[k] = 1; mEvCh[k] = c; mEvL[k] = sv;
        end else if (mDrop[k] < mDropMax[k]) begin
          mDrop[k]++;
        end
      end else if (mEvV[k] && rdy) begin
        mEvV[k] = 0;
      end
      pendOld = mPend[k];
      if (c == n - 1 && pendOld) begin
        mLen[k] = mPendLen[k];
        mPend[k] = 0;
        for (int i = 0; i < 5; i++) mHist[k][i].delete();
      end
      if (cfgV && !pendOld) begin
        mPend[k] = 1;
        mPendLen[k] = cfgL;
      end
      mPtr[k] = (c == n - 1) ? 0 : c + 1;
    end
    for (int i = 0; i < n; i++) mPrev[k][i] = inNow[i];
  endtask

  function automatic logic [4:0] lvl(input int k);
    logic [4:0] r;
    for (int i = 0; i < 5; i++) r[i] = mLevel[k][i];
    return r;
  endfunction

  always @(posedge clk) begin
    model_step(0, 4, {1'b0, bus4.inData}, rstN, bus4.cfgValid, bus4.cfgLen, bus4.evtReady);
    model_step(1, 5, bus5.inData, rstN, bus5.cfgValid, bus5.cfgLen, bus5.evtReady);
  end

  // Accepted-event monitor for the 4-channel instance.
  int   evCnt4 = 0;
  int   lastCh4 = 0;
  logic lastLv4 = 0;
  always @(posedge clk) begin
    if (rstN && bus4.evtValid && bus4.evtReady) begin
      evCnt4++;
      lastCh4 = bus4.evtCh;
      lastLv4 = bus4.evtLevel;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmpEn) begin
      chk("out4", bus4.outData, lvl(0));
      chk("cfgReady4", bus4.cfgReady, !mPend[0]);
      chk("evtValid4", bus4.evtValid, mEvV[0]);
      if (mEvV[0]) begin
        chk("evtCh4", bus4.evtCh, mEvCh[0]);
        chk("evtLevel4", bus4.evtLevel, mEvL[0]);
      end
      chk("dropCnt4", bus4.dropCnt, mDrop[0]);
      chk("out5", bus5.outData, lvl(1));
      chk("cfgReady5", bus5.cfgReady, !mPend[1]);
      chk("evtValid5", bus5.evtValid, mEvV[1]);
      if (mEvV[1]) begin
        chk("evtCh5", bus5.evtCh, mEvCh[1]);
        chk("evtLevel5", bus5.evtLevel, mEvL[1]);
      end
      chk("dropCnt5", bus5.dropCnt, mDrop[1]);
      chk("ptr5", dut5.ptr, mPtr[1]);
      chk("evtChRange5", bus5.evtCh <= 3'd4, 1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ptr4(input int p);
    int t = 0;
    while (mPtr[0] != p && t < 10) begin tick(1); t++; end
  endtask

  task automatic cfg4(input logic [7:0] len);
    int t = 0;
    while (!bus4.cfgReady && t < 40) begin tick(1); t++; end
    chk("cfg_ready_wait", bus4.cfgReady, 1);
    bus4.cfgValid = 1'b1;
    bus4.cfgLen   = len;
    tick(1);
    bus4.cfgValid = 1'b0;
  endtask

  task automatic wait_apply4();
    int t = 0;
    while (!bus4.cfgReady && t < 20) begin tick(1); t++; end
    chk("cfg_apply_wait", bus4.cfgReady, 1);
  endtask

  task automatic wait_out4(input int ch, input logic v, input int lim, output int lat);
    lat = 0;
    while (bus4.outData[ch] !== v && lat < lim) begin tick(1); lat++; end
    chk("wait_out", bus4.outData[ch], v);
  endtask

  // Random traffic on the 5-channel instance.
  initial begin
    bus5.inData = '0; bus5.cfgValid = 1'b0; bus5.cfgLen = '0; bus5.evtReady = 1'b1;
    wait (rstN === 1'b1);
    tick(1);
    bus5.cfgValid = 1'b1;
    bus5.cfgLen   = 8'd2;
    tick(1);
    bus5.cfgValid = 1'b0;
    repeat (1200) begin
      tick(1);
      for (int i = 0; i < 5; i++)
        if ($urandom_range(0, 7) == 0) bus5.inData[i] = ~bus5.inData[i];
      bus5.evtReady = ($urandom_range(0, 3) != 0);
    end
    done5 = 1;
  end

  initial begin
    int lat;
    int e0;
    int zeros;
    rstN = 1'b0;
    bus4.inData = '0; bus4.cfgValid = 1'b0; bus4.cfgLen = '0; bus4.evtReady = 1'b1;
    tick(3);
    cmpEn = 1;
    chk("rst_out", bus4.outData, 0);
    chk("rst_evtValid", bus4.evtValid, 0);
    chk("rst_cfgReady", bus4.cfgReady, 1);
    chk("rst_drop", bus4.dropCnt, 0);
    rstN = 1'b1;

    // Length 2: held level propagates after two visits; 3-clk pulse is lost.
    cfg4(8'd2);
    wait_apply4();
    e0 = evCnt4;
    bus4.inData[1] = 1'b1;
    wait_out4(1, 1'b1, 12, lat);
    chk("t1_latency_ok", lat <= 9, 1);
    tick(2);
    chk("t1_evcnt", evCnt4 - e0, 1);
    chk("t1_evch", lastCh4, 1);
    chk("t1_evlvl", lastLv4, 1);
    e0 = evCnt4;
    bus4.inData[2] = 1'b1;
    tick(3);
    bus4.inData[2] = 1'b0;
    tick(12);
    chk("t1_pulse_out", bus4.outData[2], 0);
    chk("t1_pulse_evcnt", evCnt4 - e0, 0);

    // Length 0: pass-through at scan rate.
    cfg4(8'd0);
    wait_apply4();
    e0 = evCnt4;
    bus4.inData[3] = 1'b1;
    wait_out4(3, 1'b1, 8, lat);
    chk("t2_rise_lat_ok", lat <= 5, 1);
    bus4.inData[3] = 1'b0;
    wait_out4(3, 1'b0, 8, lat);
    chk("t2_fall_lat_ok", lat <= 5, 1);
    tick(2);
    chk("t2_evcnt", evCnt4 - e0, 2);

    // Backpressure: first event held, second dropped.
    bus4.evtReady = 1'b0;
    bus4.inData[0] = 1'b1;
    wait_out4(0, 1'b1, 8, lat);
    bus4.inData[1] = 1'b0;
    wait_out4(1, 1'b0, 8, lat);
    tick(1);
    chk("t3_held_valid", bus4.evtValid, 1);
    chk("t3_held_ch", bus4.evtCh, 0);
    chk("t3_held_lvl", bus4.evtLevel, 1);
    chk("t3_drop1", bus4.dropCnt, 1);
    // Ready raised on the same edge that visits the newly changed channel.
    wait_ptr4(1);
    bus4.inData[2] = 1'b1;
    tick(1);
    bus4.evtReady = 1'b1;
    tick(1);
    bus4.evtReady = 1'b0;
    chk("t3_same_valid", bus4.evtValid, 1);
    chk("t3_same_ch", bus4.evtCh, 2);
    chk("t3_same_lvl", bus4.evtLevel, 1);
    chk("t3_same_nodrop", bus4.dropCnt, 1);
    // Saturation: every visit changes level while the event is stuck.
    repeat (30) begin
      bus4.inData = ~bus4.inData;
      tick(4);
    end
    chk("t3_sat", bus4.dropCnt, 63);
    bus4.evtReady = 1'b1;
    bus4.inData = 4'b0000;
    tick(12);
    chk("t3_drain_out", bus4.outData, 0);
    chk("t3_drain_valid", bus4.evtValid, 0);

    // Config mid-scan: accepted at ptr 1, applied on the wrap two edges later.
    wait_ptr4(1);
    bus4.cfgValid = 1'b1;
    bus4.cfgLen   = 8'd3;
    tick(1);
    bus4.cfgValid = 1'b0;
    zeros = 0;
    while (!bus4.cfgReady && zeros < 12) begin zeros++; tick(1); end
    chk("t4_ready_low", zeros, 2);
    bus4.inData[1] = 1'b1;
    wait_out4(1, 1'b1, 16, lat);
    chk("t4_len3_lat_ok", (lat >= 10) && (lat <= 13), 1);
    // Transfer on the wrap edge itself waits a whole scan.
    wait_ptr4(3);
    bus4.cfgValid = 1'b1;
    bus4.cfgLen   = 8'd1;
    tick(1);
    bus4.cfgValid = 1'b0;
    zeros = 0;
    while (!bus4.cfgReady && zeros < 12) begin zeros++; tick(1); end
    chk("t4_wrap_ready_low", zeros, 4);

    // Reset with a held event, pending config and running counters.
    cfg4(8'd4);
    wait_apply4();
    bus4.evtReady = 1'b0;
    bus4.inData[0] = 1'b1;
    wait_out4(0, 1'b1, 24, lat);
    bus4.inData[2] = 1'b1;
    tick(6);
    cfg4(8'd2);
    chk("t5_pre_pending", bus4.cfgReady, 0);
    chk("t5_pre_held", bus4.evtValid, 1);
    rstN = 1'b0;
    tick(1);
    chk("t5_out", bus4.outData, 0);
    chk("t5_evtValid", bus4.evtValid, 0);
    chk("t5_evtCh", bus4.evtCh, 0);
    chk("t5_evtLevel", bus4.evtLevel, 0);
    chk("t5_cfgReady", bus4.cfgReady, 1);
    chk("t5_drop", bus4.dropCnt, 0);
    rstN = 1'b1;
    bus4.evtReady = 1'b1;
    tick(4);
    chk("t5_default_len", bus4.outData, 4'b0111);

    wait (done5);
    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
